// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing defaults, totals and coordinate widths
package vga_timing_pkg;
  localparam int XW = 10;
  localparam int YW = 10;
  localparam int DEF_CLKDIV = 4;
  localparam int DEF_HACTIVE = 640;
  localparam int DEF_HFP = 16;
  localparam int DEF_HSW = 96;
  localparam int DEF_HBP = 48;
  localparam int DEF_VACTIVE = 480;
  localparam int DEF_VFP = 10;
  localparam int DEF_VSW = 2;
  localparam int DEF_VBP = 33;
  function automatic int sum4(input int a, input int b, input int c, input int d);
    return a + b + c + d;
  endfunction
  localparam int DEF_HTOT = sum4(DEF_HACTIVE, DEF_HFP, DEF_HSW, DEF_HBP);
  localparam int DEF_VTOT = sum4(DEF_VACTIVE, DEF_VFP, DEF_VSW, DEF_VBP);
endpackage

// File: rtl/vga_sync_gen_if.sv
// vga_sync_gen_if: video timing bundle (hsync, vsync, activevideo, x, y, pix_en, frame_start[, frame_cnt])
// master drives the bundle, slave observes it; frame_cnt exists only with VGA_FRAME_COUNT_EN.
interface vga_sync_gen_if import vga_timing_pkg::*; ();
  logic hsync;
  logic vsync;
  logic activevideo;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic pix_en;
  logic frame_start;
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_cnt;
`endif
  modport master(output hsync, vsync, activevideo, x, y, pix_en, frame_start
`ifdef VGA_FRAME_COUNT_EN
    , frame_cnt
`endif
  );
  modport slave(input hsync, vsync, activevideo, x, y, pix_en, frame_start
`ifdef VGA_FRAME_COUNT_EN
    , frame_cnt
`endif
  );
endinterface

// File: rtl/vga_pix_div.sv
// vga_pix_div: pixel strobe, pix_en high one clk out of every CLKDIV (1..16)
// Ports: clk, reset_n (async active-low), pix_en (held low during reset).
module vga_pix_div import vga_timing_pkg::*; #(
  parameter int CLKDIV = DEF_CLKDIV
) (
  input  logic clk,
  input  logic reset_n,
  output logic pix_en
);
  localparam logic [3:0] DIV_LAST = 4'(CLKDIV - 1);
  logic [3:0] div_q, div_d;
  logic div_last;
  always_comb begin
    div_last = div_q == DIV_LAST;
    div_d = div_last ? 4'd0 : div_q + 4'd1;
    pix_en = reset_n && div_last;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) div_q <= '0;
    else div_q <= div_d;
endmodule

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA x/y raster counters with zero-latency sync/active decode
// Ports: clk, reset_n (async active-low), vif (vga_sync_gen_if.master).
// Optional: define VGA_FRAME_COUNT_EN to add the 8-bit wrapping frame_cnt output.
module vga_sync_gen import vga_timing_pkg::*; #(
  parameter int CLKDIV = DEF_CLKDIV,
  parameter int HACTIVE = DEF_HACTIVE,
  parameter int HFP = DEF_HFP,
  parameter int HSW = DEF_HSW,
  parameter int HBP = DEF_HBP,
  parameter int VACTIVE = DEF_VACTIVE,
  parameter int VFP = DEF_VFP,
  parameter int VSW = DEF_VSW,
  parameter int VBP = DEF_VBP
) (
  input logic clk,
  input logic reset_n,
  vga_sync_gen_if.master vif
);
  localparam int HTOT = sum4(HACTIVE, HFP, HSW, HBP);
  localparam int VTOT = sum4(VACTIVE, VFP, VSW, VBP);
  localparam logic [XW-1:0] X_LAST = XW'(HTOT - 1);
  localparam logic [XW-1:0] X_ACT = XW'(HACTIVE);
  localparam logic [XW-1:0] HS_BEG = XW'(HACTIVE + HFP);
  localparam logic [XW-1:0] HS_END = XW'(HACTIVE + HFP + HSW);
  localparam logic [YW-1:0] Y_LAST = YW'(VTOT - 1);
  localparam logic [YW-1:0] Y_ACT = YW'(VACTIVE);
  localparam logic [YW-1:0] VS_BEG = YW'(VACTIVE + VFP);
  localparam logic [YW-1:0] VS_END = YW'(VACTIVE + VFP + VSW);
  logic pix_en;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic x_wrap, y_wrap;
  vga_pix_div #(.CLKDIV(CLKDIV)) u_div (
    .clk(clk),
    .reset_n(reset_n),
    .pix_en(pix_en)
  );
  always_comb begin
    x_wrap = x_q == X_LAST;
    y_wrap = y_q == Y_LAST;
    x_d = pix_en ? (x_wrap ? '0 : x_q + XW'(1)) : x_q;
    y_d = (pix_en && x_wrap) ? (y_wrap ? '0 : y_q + YW'(1)) : y_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  // All outputs decode straight from x_q/y_q so they never skew against each other.
  always_comb begin
    vif.x = x_q;
    vif.y = y_q;
    vif.pix_en = pix_en;
    vif.activevideo = (x_q < X_ACT) && (y_q < Y_ACT);
    vif.hsync = !((x_q >= HS_BEG) && (x_q < HS_END));
    vif.vsync = !((y_q >= VS_BEG) && (y_q < VS_END));
    vif.frame_start = pix_en && (x_q == '0) && (y_q == '0);
  end
`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;
  always_comb frame_cnt_d = frame_cnt_q + 8'(pix_en && x_wrap && y_wrap);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) frame_cnt_q <= '0;
    else frame_cnt_q <= frame_cnt_d;
  always_comb vif.frame_cnt = frame_cnt_q;
`endif
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: scoreboard bench for vga_sync_gen on a reduced 12x8 raster, CLKDIV=2
module tb_vga_sync_gen;
  import vga_timing_pkg::*;
  localparam int CD = 2;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic hs;
    logic vs;
    logic av;
    logic fs;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n;
  bit mon_on;
  int cyc;
  int n_total;
  int n_bad;
  exp_t q[$];
  vga_sync_gen_if vif();
  vga_sync_gen #(
    .CLKDIV(CD), .HACTIVE(6), .HFP(2), .HSW(2), .HBP(2),
    .VACTIVE(4), .VFP(1), .VSW(2), .VBP(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .vif(vif)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, req);
    end
  endtask
  // Raster of 12 pixels x 8 lines: hsync low x=8..9, vsync low y=5..6, active x<6 && y<4.
  task automatic push_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int xx;
      int yy;
      exp_t e;
      xx = i % 12;
      yy = (i / 12) % 8;
      e.x = 10'(xx);
      e.y = 10'(yy);
      e.hs = !(xx == 8 || xx == 9);
      e.vs = !(yy == 5 || yy == 6);
      e.av = (xx < 6) && (yy < 4);
      e.fs = (xx == 0) && (yy == 0);
      q.push_back(e);
    end
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", q.size(), 0);
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_x"}, vif.x, 0);
    chk({tag, "_y"}, vif.y, 0);
    chk({tag, "_hsync"}, vif.hsync, 1);
    chk({tag, "_vsync"}, vif.vsync, 1);
    chk({tag, "_active"}, vif.activevideo, 1);
    chk({tag, "_pix_en"}, vif.pix_en, 0);
    chk({tag, "_frame_start"}, vif.frame_start, 0);
  endtask
  // Monitor: head of queue is the expected current raster position; it is retired on each pixel tick.
  always @(negedge clk) begin
    bit pe;
    exp_t e;
    if (!reset_n) cyc = 0;
    else begin
      cyc++;
      pe = (cyc % CD) == CD - 1;
      if (mon_on) begin
        chk("pix_en", vif.pix_en, pe);
        if (q.size() > 0) begin
          e = q[0];
          chk("x", vif.x, e.x);
          chk("y", vif.y, e.y);
          chk("hsync", vif.hsync, e.hs);
          chk("vsync", vif.vsync, e.vs);
          chk("activevideo", vif.activevideo, e.av);
          chk("frame_start", vif.frame_start, e.fs && pe);
          if (pe) void'(q.pop_front());
        end
      end
    end
  end
  initial begin
    reset_n = 1'b0;
    mon_on = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("rst0");
    push_ticks(2 * 96 + 30);
    mon_on = 1'b1;
    #2 reset_n = 1'b1;
    drain();
    @(posedge clk);
    #1;
    chk("mid_x", vif.x, 6);
    chk("mid_y", vif.y, 2);
    chk("mid_active", vif.activevideo, 0);
    mon_on = 1'b0;
    reset_n = 1'b0;
    #1;
    chk_reset_state("async_rst");
    repeat (2) @(negedge clk);
    chk_reset_state("rst_hold");
    q.delete();
    push_ticks(96 + 14);
    mon_on = 1'b1;
    #2 reset_n = 1'b1;
    drain();
    mon_on = 1'b0;
`ifdef VGA_FRAME_COUNT_EN
    reset_n = 1'b0;
    @(negedge clk);
    chk("frame_cnt_rst", vif.frame_cnt, 0);
    #2 reset_n = 1'b1;
    begin
      int ticks;
      ticks = 0;
      for (int c = 0; c < 60000 && ticks <= 256 * 96; c++) begin
        @(negedge clk);
        if (vif.pix_en) begin
          chk("frame_cnt", vif.frame_cnt, (ticks / 96) % 256);
          ticks++;
        end
      end
      chk("frame_cnt_ticks", ticks, 256 * 96 + 1);
      chk("frame_cnt_wrap", vif.frame_cnt, 0);
    end
`endif
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter CLKDIV, default 4: system clocks per pixel; legal range 1..16.
REQ-002 Parameters HACTIVE/HFP/HSW/HBP, defaults 640/16/96/48: horizontal active, front porch, sync width and back porch, in pixels.
REQ-003 Parameters VACTIVE/VFP/VSW/VBP, defaults 480/10/2/33: vertical active, front porch, sync width and back porch, in lines.
REQ-004 clk  in  1  system clock; one clock domain only.
REQ-005 reset_n  in  1  reset; asynchronous assert, active-low.
REQ-006 hsync  out  1  horizontal sync; active-low.
REQ-007 vsync  out  1  vertical sync; active-low.
REQ-008 activevideo  out  1  high while (x,y) lies inside the visible region.
REQ-009 x  out  `xbits (10)  current pixel column.
REQ-010 y  out  `ybits (10)  current line.
REQ-011 pix_en  out  1  one-clk strobe; x/y advance on the edge where pix_en=1.
REQ-012 frame_start  out  1  one-clk pulse marking the first pixel tick of a frame.

Function
REQ-013 A divider counter div SHALL count 0..CLKDIV-1 and wrap; pix_en=1 iff div==CLKDIV-1; CLKDIV=1 gives pix_en constantly 1.
REQ-014 On an edge with pix_en=1: x SHALL increment; at x==HTOT-1 (HTOT=800) x SHALL wrap to 0 and y SHALL increment.
REQ-015 y SHALL wrap from VTOT-1 (VTOT=525) to 0 on the same edge where x wraps.
REQ-016 activevideo SHALL be (x<HACTIVE)&&(y<VACTIVE), decoded from the current x/y registers with zero latency.
REQ-017 hsync SHALL be 0 iff HACTIVE+HFP <= x < HACTIVE+HFP+HSW (656..751 at defaults), else 1.
REQ-018 vsync SHALL be 0 iff VACTIVE+VFP <= y < VACTIVE+VFP+VSW (490..491 at defaults), else 1.
REQ-019 frame_start SHALL be 1 iff x==0 && y==0 && pix_en==1.
REQ-020 x, y, hsync, vsync and activevideo SHALL be mutually consistent in every clk cycle, with no skew between them.
REQ-021 x/y SHALL hold their values on all clks where pix_en=0.
REQ-022 Only the in-range values 0..HTOT-1 and 0..VTOT-1 SHALL appear on x and y.

Reset
REQ-023 While reset_n=0: div=0, x=0, y=0, pix_en=0, frame_start=0, hsync=1, vsync=1, activevideo=1 (decoded at 0,0).
REQ-024 After reset_n rises, the first pix_en SHALL occur on the CLKDIV-th clk edge, and frame_start SHALL be high in that same cycle.
REQ-025 Reset asserted mid-frame SHALL immediately zero all counters, with no completion of the current line.

Configuration
REQ-026 Macro VGA_FRAME_COUNT_EN: when defined, output frame_cnt [7:0] SHALL exist.
REQ-027 frame_cnt SHALL reset to 0, increment on each edge where y wraps VTOT-1->0, and wrap from 255 to 0.
REQ-028 When VGA_FRAME_COUNT_EN is undefined, neither the port nor its register SHALL exist; all other behaviour SHALL be identical.

Structure
REQ-029 The timing defaults and HTOT/VTOT derivations SHALL live in a shared package vga_timing_pkg, reused by the display driver and the bench.
REQ-030 `xbits/`ybits SHALL continue to come from display640x480.vh.
REQ-031 One sub-module SHALL be used: vga_pix_div (the CLKDIV strobe generator); the x/y counters and decode SHALL stay in vga_sync_gen.

Verification
REQ-032 Release reset at defaults -> pix_en high on clks 3, 7, 11, ...; frame_start high on clk 3 only within the frame.
REQ-033 Run one line -> hsync low for exactly 384 clks, starting at x=656 and ending after x=751; activevideo low from x=640 to 799.
REQ-034 Reach x=799 with y=10 -> on the next pix_en edge x=0 and y=11.
REQ-035 Reach x=799 with y=524 -> x=0, y=0, frame_start=1; vsync was low only on y=490 and y=491, for 1600 pix_en ticks in total.
REQ-036 Assert reset_n=0 at x=300, y=200 for 2 clks -> x=0, y=0 and hsync=vsync=1 with no clk edge; restart timing matches REQ-032.
REQ-037 With VGA_FRAME_COUNT_EN defined, run 256 frames (CLKDIV=1) -> frame_cnt goes 0..255, then 0 on the 256th wrap.
